seq_alu: RTL

//  Parametrised multi-cycle integer ALU for the RISC-V core execute stage.

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for the sequential ALU.
// master = requester (execute stage), slave = seq_alu.
interface seq_alu_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      op_ctrl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_op;
    logic            b_zero;
    logic            busy;

    modport master (
        output in_valid, rs1, rs2, op_ctrl, out_ready,
        input  in_ready, out_valid, alu_op, b_zero, busy
    );

    modport slave (
        input  in_valid, rs1, rs2, op_ctrl, out_ready,
        output in_ready, out_valid, alu_op, b_zero, busy
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned integer ALU (add/sub/div/mul/rem/and/or/xor).
// Shift-add multiplier retiring MUL_BPC bits per cycle, restoring divider
// producing one quotient bit per cycle, one operation in flight, result held
// in DONE until the consumer takes it.
// Build option: define SEQ_ALU_FAST_MUL_EN to make mul a single-cycle
// combinational multiply (MUL state and MUL_BPC then unused).
module seq_alu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_BPC = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int unsigned MUL_STEPS = XLEN / MUL_BPC;
    localparam int unsigned CNT_W     = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_DIV = 3'b010,
        OP_MUL = 3'b011,
        OP_REM = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } op_t;

    state_t           state;
    state_t           state_nxt;
    op_t              op_in;
    op_t              op_r;
    logic             accept;
    logic             quick_op;
    logic             div_like;
    logic [XLEN-1:0]  quick_res;
    logic [CNT_W-1:0] cnt;

    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  prod;
    logic [XLEN-1:0]  prod_nxt;
    logic [XLEN-1:0]  mul_step;
    logic [XLEN-1:0]  mp;
    logic [XLEN-1:0]  mc;

    logic [XLEN-1:0]  divisor;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_nxt;
    logic [XLEN-1:0]  rem_nxt;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    rem_diff;

    logic [XLEN-1:0]  alu_q;
    logic             zero_q;

    assign op_in         = op_t'(bus.op_ctrl);
    assign accept        = bus.in_valid && (state == S_IDLE);
    assign div_like      = (op_in == OP_DIV) || (op_in == OP_REM);
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.alu_op    = alu_q;
    assign bus.b_zero    = zero_q;

`ifdef SEQ_ALU_FAST_MUL_EN
    assign quick_op = !(div_like && (bus.rs2 != '0));
`else
    assign quick_op = (op_in != OP_MUL) && !(div_like && (bus.rs2 != '0));
`endif

    // Results that complete in the accept cycle (incl. divide-by-zero cases).
    always_comb begin
        quick_res = '0;
        case (op_in)
            OP_ADD: quick_res = bus.rs1 + bus.rs2;
            OP_SUB: quick_res = bus.rs1 - bus.rs2;
            OP_DIV: quick_res = '1;
            OP_REM: quick_res = bus.rs1;
            OP_AND: quick_res = bus.rs1 & bus.rs2;
            OP_OR:  quick_res = bus.rs1 | bus.rs2;
            OP_XOR: quick_res = bus.rs1 ^ bus.rs2;
`ifdef SEQ_ALU_FAST_MUL_EN
            OP_MUL: quick_res = bus.rs1 * bus.rs2;
`else
            OP_MUL: quick_res = '0;
`endif
            default: quick_res = '0;
        endcase
    end

    // Shift-add step: sum of MUL_BPC partial products for this cycle.
    always_comb begin
        mp       = mplier;
        mc       = mcand;
        mul_step = '0;
        for (int unsigned j = 0; j < MUL_BPC; j++) begin
            if (mp[0]) begin
                mul_step = mul_step + mc;
            end
            mp = mp >> 1;
            mc = mc << 1;
        end
        prod_nxt = prod + mul_step;
    end

    // Restoring divide step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_r, quo[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, divisor};
        if (!rem_diff[XLEN]) begin
            rem_nxt = rem_diff[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = rem_shift[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (quick_op) begin
                        state_nxt = S_DONE;
                    end else if (op_in == OP_MUL) begin
                        state_nxt = S_MUL;
                    end else begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: if (cnt == '0) state_nxt = S_DONE;
            S_DIV: if (cnt == '0) state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= OP_ADD;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            divisor <= '0;
            quo     <= '0;
            rem_r   <= '0;
            alu_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r    <= op_in;
                        cnt     <= (op_in == OP_MUL) ? CNT_W'(MUL_STEPS - 1) : CNT_W'(XLEN - 1);
                        mcand   <= bus.rs1;
                        mplier  <= bus.rs2;
                        prod    <= '0;
                        divisor <= bus.rs2;
                        quo     <= bus.rs1;
                        rem_r   <= '0;
                        if (quick_op) begin
                            alu_q  <= quick_res;
                            zero_q <= (quick_res == '0);
                        end
                    end
                end
                S_MUL: begin
                    mcand  <= mcand << MUL_BPC;
                    mplier <= mplier >> MUL_BPC;
                    prod   <= prod_nxt;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        alu_q  <= prod_nxt;
                        zero_q <= (prod_nxt == '0);
                    end
                end
                S_DIV: begin
                    rem_r <= rem_nxt;
                    quo   <= quo_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (op_r == OP_REM) begin
                            alu_q  <= rem_nxt;
                            zero_q <= (rem_nxt == '0);
                        end else begin
                            alu_q  <= quo_nxt;
                            zero_q <= (quo_nxt == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
